serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_if.sv | 30 +++
 rtl/serial_subtractor.sv | 66 ++++++
 tb/tb_serial_subtractor.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: request/result bundle for the bit-serial subtractor
// Signals: start/a/b/bin driven by the master; busy/done/diff/bout (and ovf when
// SERIAL_SUB_OVF_EN is defined) driven by the slave.
interface serial_subtractor_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif
    modport master (
`ifdef SERIAL_SUB_OVF_EN
        input  ovf,
`endif
        output start, a, b, bin,
        input  busy, done, diff, bout
    );
    modport slave (
`ifdef SERIAL_SUB_OVF_EN
        output ovf,
`endif
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, one bit per cycle, LSB first
// Ports: clk, rst (sync active-high); bus (slave): start, a, b, bin in;
// busy, done, diff, bout out; ovf out only when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(parameter int WIDTH = 8) (
    input logic             clk,
    input logic             rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a, r_b, r_diff;
    logic             r_br, r_bout;
    logic             w_ai, w_bi, w_d, w_brn, w_last, w_accept;
    assign w_ai     = r_a[r_cnt];
    assign w_bi     = r_b[r_cnt];
    assign w_d      = w_ai ^ w_bi ^ r_br;
    assign w_brn    = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
    assign w_last   = r_cnt == CW'(WIDTH - 1);
    assign w_accept = r_state == IDLE && bus.start;
    always_ff @(posedge clk)
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end
`ifdef SERIAL_SUB_OVF_EN
    logic r_ovf;
    // w_d on the last bit is the sign bit of the result
    always_ff @(posedge clk)
        if (rst) r_ovf <= 1'b0;
        else if (r_state == RUN && w_last) r_ovf <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_d != r_a[WIDTH-1]);
    assign bus.ovf = r_ovf;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_br   <= 1'b0;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_a    <= bus.a;
            r_b    <= bus.b;
            r_br   <= bus.bin;
            r_diff <= '0;
            r_cnt  <= '0;
        end else if (r_state == RUN) begin
            r_diff[r_cnt] <= w_d;
            r_br          <= w_brn;
            r_cnt         <= r_cnt + CW'(1);
            if (w_last) r_bout <= w_brn;
        end
    end
    assign bus.busy = r_state == RUN;
    assign bus.done = r_state == DONE;
    assign bus.diff = r_diff;
    assign bus.bout = r_bout;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;
    localparam int W = 8;
    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sbq[$];
    serial_subtractor_if #(.WIDTH(W)) bus();
    serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin);
        logic [W:0] full;
        exp_t e;
        full   = {1'b0, ta} - {1'b0, tb_} - {{W{1'b0}}, tbin};
        e.diff = full[W-1:0];
        e.bout = full[W];
        e.ovf  = (ta[W-1] != tb_[W-1]) && (full[W-1] != ta[W-1]);
        return e;
    endfunction
    always @(negedge clk) begin
        exp_t e;
        if (bus.done) begin
            if (sbq.size() == 0) check("unexpected_done", 1, 0);
            else begin
                e = sbq.pop_front();
                check("diff", bus.diff, e.diff);
                check("bout", bus.bout, e.bout);
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", bus.ovf, e.ovf);
`endif
            end
        end
    end
    task automatic wait_idle();
        int k = 0;
        while ((bus.busy || bus.done) && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k == 50) check("idle_timeout", 0, 1);
    endtask
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin);
        exp_t e;
        logic [W-1:0] m;
        int n = 0;
        bit seen = 0;
        e = model(ta, tb_, tbin);
        wait_idle();
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_;
        bus.bin   = tbin;
        sbq.push_back(e);
        @(posedge clk);
        #1 bus.start = 1'b0;
        while (!seen && n < 4 * W) begin
            @(negedge clk);
            if (bus.done) seen = 1;
            else begin
                m = (W'(1) << n) - W'(1);
                check("busy_run", bus.busy, 1);
                check("partial_diff", bus.diff, e.diff & m);
                @(posedge clk);
                #1;
                n++;
                bus.a   = W'($urandom);
                bus.b   = W'($urandom);
                bus.bin = 1'($urandom);
            end
        end
        if (!seen) check("done_timeout", 0, 1);
        else begin
            check("latency", n, W);
            check("busy_in_done", bus.busy, 0);
            @(negedge clk);
            check("done_pulse", bus.done, 0);
            check("hold_diff", bus.diff, e.diff);
            check("hold_bout", bus.bout, e.bout);
`ifdef SERIAL_SUB_OVF_EN
            check("hold_ovf", bus.ovf, e.ovf);
`endif
        end
    endtask
    initial begin
        int dn;
        bus.start = 1'b1;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_diff", bus.diff, 0);
        check("rst_bout", bus.bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", bus.ovf, 0);
`endif
        bus.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        run_op(8'd5, 8'd3, 1'b0);
        run_op(8'd3, 8'd5, 1'b0);
        run_op(8'h80, 8'h01, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1);
        run_op(8'h7F, 8'h80, 1'b0);
        for (int i = 0; i < 6; i++) run_op(W'($urandom), W'($urandom), 1'($urandom));
        wait_idle();
        bus.start = 1'b1;
        bus.a     = 8'd9;
        bus.b     = 8'd4;
        bus.bin   = 1'b0;
        sbq.push_back(model(8'd9, 8'd4, 1'b0));
        sbq.push_back(model(8'd9, 8'd4, 1'b0));
        dn = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) dn++;
        end
        bus.start = 1'b0;
        check("hold_start_ops", dn, 2);
        check("hold_start_sb", sbq.size(), 0);
        run_op(8'd0, 8'd0, 1'b1);
        wait_idle();
        bus.start = 1'b1;
        bus.a     = 8'h55;
        bus.b     = 8'h0F;
        bus.bin   = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_diff", bus.diff, 0);
        check("abort_bout", bus.bout, 0);
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        check("abort_no_done", dn, 0);
        run_op(8'd7, 8'd7, 1'b0);
        repeat (3) @(negedge clk);
        check("sb_left", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
